// File: rtl/serial_word_comparator_fsm.sv
// Serial magnitude comparator for fixed-length words streamed one bit per valid cycle.
// Bit order and signedness are fixed at elaboration; gives a live verdict plus a registered per-word result.
module serial_word_comparator_fsm #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit SIGNED    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  input  logic a,
  input  logic b,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b,
  output logic res_valid,
  output logic res_less,
  output logic res_eq,
  output logic res_greater
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] SIGN_IDX = MSB_FIRST ? '0 : LAST_IDX;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {
    ST_EQUAL   = 2'd0,
    ST_LESS    = 2'd1,
    ST_GREATER = 2'd2
  } state_t;

  state_t        state_q, state_d, verdict, shown;
  logic [IW-1:0] idx_q, idx_d;
  logic          lt_raw, gt_raw, lt_bit, gt_bit, sign_pos, last_bit, load;

  // Verdict after folding in the current bit (only meaningful while valid=1).
  always_comb begin
    lt_raw   = ~a & b;
    gt_raw   = a & ~b;
    // At the two's-complement sign bit a set bit means "more negative".
    sign_pos = SIGNED && (idx_q == SIGN_IDX);
    lt_bit   = sign_pos ? gt_raw : lt_raw;
    gt_bit   = sign_pos ? lt_raw : gt_raw;

    verdict = state_q;
    if (MSB_FIRST) begin
      // The first differing bit from the top decides; later bits cannot override it.
      if (state_q == ST_EQUAL) begin
        if (lt_bit)      verdict = ST_LESS;
        else if (gt_bit) verdict = ST_GREATER;
      end
    end else begin
      // LSB first: the most recent differing bit is the most significant so far.
      if (lt_bit)      verdict = ST_LESS;
      else if (gt_bit) verdict = ST_GREATER;
    end
  end

  // NOTE: every variable written here is given a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_bit = valid && (idx_q == LAST_IDX);
    load     = 1'b0;
    if (clear) begin
      state_d = ST_EQUAL;
      idx_d   = '0;
    end else if (valid) begin
      if (last_bit) begin
        state_d = ST_EQUAL;
        idx_d   = '0;
        load    = 1'b1;
      end else begin
        state_d = verdict;
        idx_d   = idx_q + IDX_ONE;
      end
    end
  end

  // Running outputs hold "equal" while reset is asserted regardless of the bit inputs.
  always_comb begin
    shown = ST_EQUAL;
    if (rst) shown = valid ? verdict : state_q;
    a_less_b    = (shown == ST_LESS);
    a_greater_b = (shown == ST_GREATER);
    a_eq_b      = (shown == ST_EQUAL);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EQUAL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the result registers are reset so res_* read as 0 before the first word completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
    end else begin
      res_valid <= load;
      if (load) begin
        res_less    <= (verdict == ST_LESS);
        res_eq      <= (verdict == ST_EQUAL);
        res_greater <= (verdict == ST_GREATER);
      end
    end
  end

endmodule

// File: tb/tb_serial_word_comparator_fsm.sv
// Directed bench for serial_word_comparator_fsm: four WIDTH=4 builds (order x signedness)
// share one bit stream; each scenario checks the build it targets against hand-computed values.
module tb_serial_word_comparator_fsm;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic clk = 1'b0;
  logic rst, clear, valid, a, b;
  // Index: 0 = MSB-first unsigned, 1 = LSB-first unsigned, 2 = MSB-first signed, 3 = LSB-first signed
  logic [3:0] run_lt, run_eq, run_gt, res_v, res_l, res_e, res_g;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (res_v[0] === 1'b1) strobes <= strobes + 1;

  serial_word_comparator_fsm #(.WIDTH(4), .MSB_FIRST(1'b1), .SIGNED(1'b0)) u_mu (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .a(a), .b(b),
    .a_less_b(run_lt[0]), .a_eq_b(run_eq[0]), .a_greater_b(run_gt[0]),
    .res_valid(res_v[0]), .res_less(res_l[0]), .res_eq(res_e[0]), .res_greater(res_g[0]));

  serial_word_comparator_fsm #(.WIDTH(4), .MSB_FIRST(1'b0), .SIGNED(1'b0)) u_lu (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .a(a), .b(b),
    .a_less_b(run_lt[1]), .a_eq_b(run_eq[1]), .a_greater_b(run_gt[1]),
    .res_valid(res_v[1]), .res_less(res_l[1]), .res_eq(res_e[1]), .res_greater(res_g[1]));

  serial_word_comparator_fsm #(.WIDTH(4), .MSB_FIRST(1'b1), .SIGNED(1'b1)) u_ms (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .a(a), .b(b),
    .a_less_b(run_lt[2]), .a_eq_b(run_eq[2]), .a_greater_b(run_gt[2]),
    .res_valid(res_v[2]), .res_less(res_l[2]), .res_eq(res_e[2]), .res_greater(res_g[2]));

  serial_word_comparator_fsm #(.WIDTH(4), .MSB_FIRST(1'b0), .SIGNED(1'b1)) u_ls (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .a(a), .b(b),
    .a_less_b(run_lt[3]), .a_eq_b(run_eq[3]), .a_greater_b(run_gt[3]),
    .res_valid(res_v[3]), .res_less(res_l[3]), .res_eq(res_e[3]), .res_greater(res_g[3]));

  function automatic logic [2:0] run_of(input int i);
    return {run_lt[i], run_eq[i], run_gt[i]};
  endfunction

  // {res_valid, res_less, res_eq, res_greater}
  function automatic logic [3:0] res_of(input int i);
    return {res_v[i], res_l[i], res_e[i], res_g[i]};
  endfunction

  // Drive one cycle's inputs on the falling edge, then settle.
  task automatic bit_step(input logic va, input logic vb, input logic vv);
    @(negedge clk);
    a = va; b = vb; valid = vv; clear = 1'b0;
    #1;
  endtask

  task automatic idle_cycle();
    bit_step(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  // Stream one 4-bit word and check instance inst's running verdict after each bit.
  task automatic send_word(input int inst, input logic msbf, input logic [3:0] wa,
                           input logic [3:0] wb, input logic [11:0] exp_run, input string name);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = msbf ? 3 - k : k;
      bit_step(wa[p], wb[p], 1'b1);
      checks++;
      if (run_of(inst) !== exp_run[11 - 3*k -: 3]) begin
        failures++;
        $display("FAIL %s bit%0d running: got %b expected %b", name, k, run_of(inst), exp_run[11 - 3*k -: 3]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_of(i) !== 4'b0000 || run_of(i) !== EQ) begin
        failures++;
        $display("FAIL reset inst%0d: got res=%b run=%b expected res=0000 run=%b", i, res_of(i), run_of(i), EQ);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_msb_unsigned();
    send_word(0, 1'b1, 4'b1010, 4'b1001, {EQ, EQ, GT, GT}, "msb_unsigned");
    checks++;
    if (res_of(0) !== 4'b1001) begin
      failures++; $display("FAIL msb_unsigned result: got %b expected 1001", res_of(0));
    end
    idle_cycle();
    checks++;
    if (res_of(0) !== 4'b0001 || run_of(0) !== EQ) begin
      failures++; $display("FAIL msb_unsigned hold: got res=%b run=%b expected res=0001 run=%b", res_of(0), run_of(0), EQ);
    end
  endtask

  task automatic test_lsb_unsigned();
    send_word(1, 1'b0, 4'b0011, 4'b0101, {EQ, GT, LT, LT}, "lsb_unsigned");
    checks++;
    if (res_of(1) !== 4'b1100) begin
      failures++; $display("FAIL lsb_unsigned result: got %b expected 1100", res_of(1));
    end
    idle_cycle();
  endtask

  task automatic test_msb_signed();
    send_word(2, 1'b1, 4'b1000, 4'b0111, {LT, LT, LT, LT}, "msb_signed");
    checks++;
    if (res_of(2) !== 4'b1100) begin
      failures++; $display("FAIL msb_signed result: got %b expected 1100", res_of(2));
    end
    checks++;
    if (res_of(0) !== 4'b1001) begin
      failures++; $display("FAIL msb_signed unsigned_build: got %b expected 1001", res_of(0));
    end
    idle_cycle();
  endtask

  task automatic test_lsb_signed();
    send_word(3, 1'b0, 4'b0001, 4'b1111, {EQ, LT, LT, GT}, "lsb_signed");
    checks++;
    if (res_of(3) !== 4'b1001) begin
      failures++; $display("FAIL lsb_signed result: got %b expected 1001", res_of(3));
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobes;
    send_word(0, 1'b1, 4'b0110, 4'b0110, {EQ, EQ, EQ, EQ}, "b2b_word1");
    checks++;
    if (res_of(0) !== 4'b1010) begin
      failures++; $display("FAIL b2b_word1 result: got %b expected 1010", res_of(0));
    end
    bit_step(1'b0, 1'b0, 1'b1);
    bit_step(1'b1, 1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      bit_step(1'b0, 1'b1, 1'b0);
      checks++;
      if (u_mu.idx_q !== 2'd2 || run_of(0) !== EQ || res_v[0] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_gap%0d: got idx=%0d run=%b res_valid=%b expected idx=2 run=%b res_valid=0",
                 g, u_mu.idx_q, run_of(0), res_v[0], EQ);
      end
    end
    bit_step(1'b1, 1'b1, 1'b1);
    bit_step(1'b1, 1'b0, 1'b1);
    checks++;
    if (run_of(0) !== GT) begin
      failures++; $display("FAIL b2b_word2 running: got %b expected %b", run_of(0), GT);
    end
    @(posedge clk); #1;
    checks++;
    if (res_of(0) !== 4'b1001) begin
      failures++; $display("FAIL b2b_word2 result: got %b expected 1001", res_of(0));
    end
    idle_cycle();
    checks++;
    if (strobes - s0 !== 2) begin
      failures++; $display("FAIL b2b_strobes: got %0d expected 2", strobes - s0);
    end
  endtask

  task automatic test_clear();
    int s0;
    s0 = strobes;
    bit_step(1'b1, 1'b0, 1'b1);
    bit_step(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    clear = 1'b1; valid = 1'b1; a = 1'b1; b = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (res_of(0) !== 4'b0001 || u_mu.idx_q !== 2'd0) begin
      failures++; $display("FAIL clear_abort: got res=%b idx=%0d expected res=0001 idx=0", res_of(0), u_mu.idx_q);
    end
    send_word(0, 1'b1, 4'b0001, 4'b0010, {EQ, EQ, LT, LT}, "clear_word");
    checks++;
    if (res_of(0) !== 4'b1100) begin
      failures++; $display("FAIL clear_word result: got %b expected 1100", res_of(0));
    end
    idle_cycle();
    checks++;
    if (strobes - s0 !== 1) begin
      failures++; $display("FAIL clear_strobes: got %0d expected 1", strobes - s0);
    end
  endtask

  task automatic test_reset_midword();
    int s0;
    s0 = strobes;
    bit_step(1'b0, 1'b1, 1'b1);
    bit_step(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if (res_of(0) !== 4'b0000 || run_of(0) !== EQ || u_mu.idx_q !== 2'd0) begin
      failures++;
      $display("FAIL reset_midword: got res=%b run=%b idx=%0d expected res=0000 run=%b idx=0",
               res_of(0), run_of(0), u_mu.idx_q, EQ);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    idle_cycle();
    checks++;
    if (strobes - s0 !== 0) begin
      failures++; $display("FAIL reset_strobes: got %0d expected 0", strobes - s0);
    end
    send_word(0, 1'b1, 4'b0100, 4'b0011, {EQ, GT, GT, GT}, "post_reset");
    checks++;
    if (res_of(0) !== 4'b1001) begin
      failures++; $display("FAIL post_reset result: got %b expected 1001", res_of(0));
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_msb_unsigned();
    test_lsb_unsigned();
    test_msb_signed();
    test_lsb_signed();
    test_back_to_back();
    test_clear();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator_fsm.md
# serial_word_comparator_fsm

Parametrised serial magnitude comparator for fixed-length words streamed one bit per cycle under a valid qualifier. Supports MSB-first or LSB-first ordering and unsigned or two's-complement operands, chosen at elaboration. Provides a live running verdict on every cycle and a registered per-word result with a one-cycle strobe. Sits after the serial receive path, replacing single-mode free-running comparators where word framing and signed compare are needed.

## Interface
- WIDTH, 8: bits per word; legal range 2..64.
- MSB_FIRST, 1: 1 = most significant bit arrives first; 0 = least significant bit first.
- SIGNED, 0: 1 = operands are two's complement; 0 = unsigned.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserted while 0, takes effect immediately without a clock edge.
- clear  input  1  synchronous abort; discards the partial word.
- valid  input  1  a and b carry a word bit this cycle.
- a  input  1  serial bit of operand A.
- b  input  1  serial bit of operand B.
- a_less_b  output  1  running verdict, combinational, includes the current bit when valid.
- a_eq_b  output  1  running verdict, combinational.
- a_greater_b  output  1  running verdict, combinational.
- res_valid  output  1  one-cycle strobe; a new word result is present on res_*.
- res_less  output  1  registered final result, held until the next word completes.
- res_eq  output  1  registered final result.
- res_greater  output  1  registered final result.

## Operation
- FSM states: ST_EQUAL, ST_LESS, ST_GREATER. Bit counter `idx`, width $clog2(WIDTH), counts accepted bits 0..WIDTH-1.
- Sign position: idx==0 when MSB_FIRST=1; idx==WIDTH-1 when MSB_FIRST=0. It is used only when SIGNED=1.
- Per-bit verdict: lt_bit = ~a & b, gt_bit = a & ~b. At the sign position with SIGNED=1, lt_bit and gt_bit are swapped.
- MSB_FIRST=1 transitions: from ST_EQUAL, go to ST_LESS on lt_bit and to ST_GREATER on gt_bit. ST_LESS and ST_GREATER are sticky for the rest of the word.
- MSB_FIRST=0 transitions: any state goes to ST_LESS on lt_bit and to ST_GREATER on gt_bit. An equal bit keeps the current state.
- Bits are processed only when valid=1. valid=0 freezes the state and idx.
- Last bit (valid && idx==WIDTH-1):
  - next-state verdict is written into res_*; exactly one of res_less, res_eq, res_greater is 1;
  - res_valid is set;
  - idx returns to 0 and the FSM returns to ST_EQUAL.
  - The next word may start on the following cycle with no bubble.
- Running outputs:
  - with valid=1, they show the next-state verdict;
  - with valid=0, they show the current state only: a_eq_b=1 iff ST_EQUAL.
  - Exactly one running output is 1 at all times.
- clear=1: idx goes to 0 and the FSM to ST_EQUAL. res_* hold their values and res_valid is 0.
- clear and valid in the same cycle: clear wins and the bit is discarded.

## Timing
- Reset values: state ST_EQUAL, idx=0, res_valid=0, res_less=0, res_eq=0, res_greater=0. Running a_eq_b=1 while rst=0.
- Reset mid-word drops the partial word; no res_valid is produced for it.
- Running outputs have zero latency (same cycle as the bit).
- Registered result: res_valid and res_* update on the clock edge that accepts bit WIDTH-1 and are visible the next cycle. res_valid is high for exactly 1 cycle unless another word completes on the next edge.
- Throughput: one word per WIDTH valid cycles. Gaps in valid only stretch the word; they never alter the result.

## Test plan
- WIDTH=4, MSB_FIRST=1, SIGNED=0; A=1010, B=1001 sent 1,0,1,0 / 1,0,0,1 with valid=1:
  - running a_greater_b=1 from the 3rd bit onward;
  - the cycle after the 4th bit: res_valid=1 for one cycle, res_greater=1.
- WIDTH=4, MSB_FIRST=0, SIGNED=0; A=0011, B=0101 sent LSB first:
  - running verdict goes eq, greater, less, less;
  - res_less=1.
- WIDTH=4, MSB_FIRST=1, SIGNED=1; A=1000 (-8), B=0111 (+7):
  - a_less_b=1 from the 1st bit;
  - res_less=1, where the unsigned build gives res_greater.
- WIDTH=4, MSB_FIRST=0, SIGNED=1; A=0001 (+1), B=1111 (-1):
  - running verdict is less after bits 1-2;
  - sign bit flips it to greater; res_greater=1.
- Back-to-back and gaps: A=B=0110, then immediately A=0111, B=0110 with valid=0 for 3 cycles after the 2nd bit:
  - two res_valid strobes: res_eq=1, then res_greater=1;
  - idx frozen during the gap.
- Abort and reset:
  - clear after 2 bits, then a full word A=0001, B=0010 → exactly one res_valid, with res_less=1;
  - rst=0 mid-word → res_* become 0 immediately and no strobe is produced.
